ifid_pipe_reg: RTL and testbench
================================

# ifid_pipe_reg

Parametrised IF/ID pipeline register with a valid/ready handshake, two-entry skid storage, and a flush port. It sits between instruction fetch and decode. It carries the instruction word and its program counter. It adds back-pressure (decode stall) and bubble insertion (branch/jump flush), which the plain clocked register does not support. Full throughput of one instruction per cycle is kept under intermittent stalls.

## Interface
- `INSTR_W`, 32: instruction word width.
- `PC_W`, 8: program counter width.
- `NOP_INSTR`, 0 (INSTR_W bits): word driven on `out_instr` after reset or flush.
- `CNT_W`, 16: width of performance counters (only with `IFID_PERF_EN`).

Ports:
- `clk`  in  1: the single clock; all state updates on the rising edge.
- `rst`  in  1: reset, asynchronous and active-high.
- `in_valid`  in  1: fetch presents a beat.
- `in_ready`  out  1: the block can accept a beat this cycle.
- `in_instr`  in  INSTR_W: fetched instruction.
- `in_pc`  in  PC_W: PC of the fetched instruction.
- `out_valid`  out  1: decode-side beat valid.
- `out_ready`  in  1: decode accepts the beat.
- `out_instr`  out  INSTR_W: instruction to decode.
- `out_pc`  out  PC_W: PC to decode.
- `flush`  in  1: discard all held and incoming beats.
- `stall_cnt`  out  CNT_W: cycles with `out_valid && !out_ready` (only with `IFID_PERF_EN`).
- `flush_cnt`  out  CNT_W: cycles with `flush` high (only with `IFID_PERF_EN`).

## Operation
- Storage: a main register (drives outputs) and one skid register, in strict FIFO order.
- State machine `EMPTY` / `FULL` / `SKID`:
  - `EMPTY`: `out_valid` = 0.
  - `FULL`: main holds a beat.
  - `SKID`: main and skid both hold beats.
- Handshake signals:
  - in-accept = `in_valid && in_ready`.
  - out-accept = `out_valid && out_ready`.
- Transitions when `flush` is low:
  - `EMPTY` + in-accept → `FULL`; main ← input.
  - `FULL` + in-accept + out-accept → `FULL`; main ← input.
  - `FULL` + in-accept, no out-accept → `SKID`; skid ← input.
  - `FULL` + out-accept only → `EMPTY`.
  - `SKID` + out-accept → `FULL`; main ← skid.
  - All other cases hold state and data.
- `in_ready` = (state != `SKID`). It is decoded from the state register only, so it never depends combinationally on `out_ready`.
- Output data and valid are never combinational from inputs.
- Data stability: while `out_valid && !out_ready`, `out_instr` and `out_pc` hold constant.
- `flush` high: next state is `EMPTY`, `out_instr` ← `NOP_INSTR`, `out_pc` ← 0.
  - Any beat presented on the same cycle is dropped, even if in-accept is true.
  - Flush has priority over every other event.
- Reset (any time, including mid-transfer): state `EMPTY`, `out_valid` 0, `out_instr` = `NOP_INSTR`, `out_pc` 0, `in_ready` 1, counters 0. Skid contents are don't-care.
- `out_pc` passes through unmodified; there is no PC arithmetic.

## Timing
- Latency: one cycle from in-accept (in `EMPTY`) to `out_valid`.
- Throughput: one beat per cycle while `out_ready` stays high.
- After `out_ready` falls, at most one further beat is accepted (into skid). `in_ready` drops in the following cycle.
- From `SKID`, `in_ready` rises one cycle after the out-accept that drains to `FULL`.
- Flush takes effect at the next edge: `out_valid` is 0 and `in_ready` is 1 in the cycle after `flush` is sampled.
- Counters:
  - Increment by 1 per qualifying cycle and saturate at all-ones (no wrap).
  - A cycle with `flush` high does not count as a stall cycle.

## Configuration
- `IFID_PERF_EN` defined: `stall_cnt` and `flush_cnt` ports and their counters exist, behaving as above.
- Not defined: both ports and all counter logic are absent. Pipeline behaviour is otherwise identical.

## Structure
- Shared package `ifid_pkg` holds:
  - state enum `ifid_state_t` (`EMPTY`, `FULL`, `SKID`);
  - default width constants (`INSTR_W_DEF` = 32, `PC_W_DEF` = 8);
  - `NOP_INSTR_DEF`.
- One natural sub-module, `sat_counter`: parametrised width, increment enable, saturating. It is instantiated twice under `IFID_PERF_EN`.

## Test plan
- Reset then idle → `out_valid` 0, `out_instr` 0, `out_pc` 0, `in_ready` 1. Push instr 0xDEADBEEF, PC 0x04 with `out_ready` 1 → out_valid next cycle with matching data.
- Stream PCs 0x00–0x1C (8 beats) with `out_ready` held low from beat 3 for 4 cycles → beats 3 and 4 held in order, `in_ready` low, no loss or duplication, `stall_cnt` = 4.
- State `SKID`, assert `flush` together with `in_valid` (PC 0x40) → next cycle `out_valid` 0, `out_instr` = `NOP_INSTR`, `in_ready` 1. PC 0x40 never appears; `flush_cnt` = 1.
- Assert `rst` asynchronously mid-cycle while in `FULL` → outputs reach reset values immediately, before the next edge.
- Random `in_valid`/`out_ready` over 10,000 cycles against a scoreboard → in-order, lossless delivery, with `out_*` stable whenever stalled.
- `IFID_PERF_EN` with `CNT_W` = 4, hold a stall for 20 cycles → `stall_cnt` saturates at 15.

Source files
------------

// File: rtl/ifid_pkg.sv
// ifid_pkg: shared state encoding and default widths for the IF/ID pipeline register
package ifid_pkg;
    typedef enum logic [1:0] {EMPTY, FULL, SKID} ifid_state_t;
    localparam int INSTR_W_DEF = 32;
    localparam int PC_W_DEF = 8;
    localparam logic [INSTR_W_DEF-1:0] NOP_INSTR_DEF = '0;
endpackage

// File: rtl/ifid_pipe_reg_sat_counter.sv
// sat_counter: saturating up-counter with increment enable, async active-high reset
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt
);
    always_ff @(posedge clk or posedge rst)
        if (rst) cnt <= '0;
        else if (inc && cnt != '1) cnt <= cnt + 1'b1;
endmodule

// File: rtl/ifid_pipe_reg.sv
// ifid_pipe_reg: IF/ID pipeline register with valid/ready handshake, skid slot and flush
// Performance counters (stall_cnt, flush_cnt) exist only when IFID_PERF_EN is defined.
module ifid_pipe_reg
    import ifid_pkg::*;
#(
    parameter int INSTR_W = INSTR_W_DEF,
    parameter int PC_W = PC_W_DEF,
    parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(NOP_INSTR_DEF)
`ifdef IFID_PERF_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [PC_W-1:0]    in_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [PC_W-1:0]    out_pc,
    input  logic               flush
`ifdef IFID_PERF_EN
    ,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   flush_cnt
`endif
);
    ifid_state_t state, state_nx;
    logic [INSTR_W-1:0] skid_instr;
    logic [PC_W-1:0] skid_pc;
    logic in_acc, out_acc, load_in, load_skid, load_from_skid;
    assign in_ready = state != SKID;
    assign out_valid = state != EMPTY;
    assign in_acc = in_valid && in_ready;
    assign out_acc = out_valid && out_ready;
    assign load_in = !flush && in_acc && (state == EMPTY || out_acc);
    assign load_skid = !flush && in_acc && state == FULL && !out_acc;
    assign load_from_skid = !flush && state == SKID && out_acc;
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= EMPTY;
        else state <= state_nx;
    always_comb begin
        state_nx = flush ? EMPTY
                 : state == EMPTY ? (in_acc ? FULL : EMPTY)
                 : state == FULL ? (in_acc && !out_acc ? SKID : !in_acc && out_acc ? EMPTY : FULL)
                 : (out_acc ? FULL : SKID);
    end
    // main register drives the outputs directly, so they never see input combinationally
    always_ff @(posedge clk or posedge rst)
        if (rst || flush) begin
            out_instr <= NOP_INSTR;
            out_pc <= '0;
        end else if (load_from_skid) begin
            out_instr <= skid_instr;
            out_pc <= skid_pc;
        end else if (load_in) begin
            out_instr <= in_instr;
            out_pc <= in_pc;
        end
    always_ff @(posedge clk)
        if (load_skid) begin
            skid_instr <= in_instr;
            skid_pc <= in_pc;
        end
`ifdef IFID_PERF_EN
    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk(clk),
        .rst(rst),
        .inc(out_valid && !out_ready && !flush),
        .cnt(stall_cnt)
    );
    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk(clk),
        .rst(rst),
        .inc(flush),
        .cnt(flush_cnt)
    );
`endif
endmodule

// File: tb/tb_ifid_pipe_reg.sv
// tb_ifid_pipe_reg: directed vector table plus handshake sequences for ifid_pipe_reg
module tb_ifid_pipe_reg;
    localparam bit T = 1'b1;
    localparam bit F = 1'b0;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, flush = 1'b0;
    logic [31:0] in_instr = '0, out_instr;
    logic [7:0] in_pc = '0, out_pc;
    int total = 0, bad = 0;
`ifdef IFID_PERF_EN
    logic [3:0] stall_cnt, flush_cnt;
`endif

    ifid_pipe_reg #(
        .INSTR_W(32),
        .PC_W(8),
        .NOP_INSTR(32'h0)
`ifdef IFID_PERF_EN
        ,
        .CNT_W(4)
`endif
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_instr(in_instr),
        .in_pc(in_pc),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_instr(out_instr),
        .out_pc(out_pc),
        .flush(flush)
`ifdef IFID_PERF_EN
        ,
        .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic iv, ordy, fl;
        logic [31:0] ins;
        logic [7:0] pc;
        logic ev, er, cd;
        logic [31:0] ei;
        logic [7:0] ep;
    } vec_t;

    vec_t tbl[18];

    function automatic vec_t mk(input bit iv, ordy, fl, input logic [31:0] ins, input logic [7:0] pc,
                                input bit ev, er, cd, input logic [31:0] ei, input logic [7:0] ep);
        vec_t v;
        v.iv = iv; v.ordy = ordy; v.fl = fl; v.ins = ins; v.pc = pc;
        v.ev = ev; v.er = er; v.cd = cd; v.ei = ei; v.ep = ep;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        flush = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Cycle-level scoreboard: queue of accepted beats, compared on every out-accept
    task automatic run(input int cycles, input bit rnd, input int want_beats);
        logic [39:0] q[$];
        logic [39:0] held;
        bit held_v = 0;
        int sent = 0, got = 0;
        bit ia, oa;
        for (int c = 0; c < cycles; c++) begin
            if (c >= cycles - 4) begin
                in_valid = 1'b0;
                out_ready = 1'b1;
            end else if (rnd) begin
                in_valid = $urandom_range(0, 3) != 0;
                out_ready = $urandom_range(0, 2) != 0;
            end else begin
                in_valid = sent < want_beats;
                out_ready = !(c >= 3 && c <= 6);
            end
            in_instr = 32'hC000_0000 + 32'(sent);
            in_pc = 8'(sent * 4);
            if (held_v) begin
                chk("stall_valid", out_valid, 1'b1);
                chk("stall_data", {out_instr, out_pc}, held);
            end
            if (!rnd && c >= 4 && c <= 6) chk("skid_in_ready", in_ready, 1'b0);
            ia = in_valid && in_ready;
            oa = out_valid && out_ready;
            if (oa) begin
                if (q.size() == 0) chk("spurious_beat", {out_instr, out_pc}, 40'h0);
                else chk("order", {out_instr, out_pc}, q.pop_front());
                got++;
            end
            if (ia) begin
                q.push_back({in_instr, in_pc});
                sent++;
            end
            held_v = out_valid && !out_ready;
            held = {out_instr, out_pc};
            @(posedge clk);
            @(negedge clk);
        end
        chk("drained", q.size(), 0);
        chk("drain_valid", out_valid, 1'b0);
        if (!rnd) chk("delivered", got, want_beats);
    endtask

    initial begin
        tbl[0]  = mk(T, T, F, 32'hDEADBEEF, 8'h04, T, T, T, 32'hDEADBEEF, 8'h04);
        tbl[1]  = mk(T, T, F, 32'h11111111, 8'h08, T, T, T, 32'h11111111, 8'h08);
        tbl[2]  = mk(T, F, F, 32'h22222222, 8'h0C, T, F, T, 32'h11111111, 8'h08);
        tbl[3]  = mk(T, F, F, 32'h33333333, 8'h10, T, F, T, 32'h11111111, 8'h08);
        tbl[4]  = mk(T, T, F, 32'h33333333, 8'h10, T, T, T, 32'h22222222, 8'h0C);
        tbl[5]  = mk(T, T, F, 32'h33333333, 8'h10, T, T, T, 32'h33333333, 8'h10);
        tbl[6]  = mk(F, T, F, 32'h0, 8'h00, F, T, F, 32'h0, 8'h00);
        tbl[7]  = mk(F, F, F, 32'h0, 8'h00, F, T, F, 32'h0, 8'h00);
        tbl[8]  = mk(T, F, F, 32'h44444444, 8'h14, T, T, T, 32'h44444444, 8'h14);
        tbl[9]  = mk(T, F, F, 32'h55555555, 8'h18, T, F, T, 32'h44444444, 8'h14);
        tbl[10] = mk(T, F, T, 32'h66666666, 8'h40, F, T, T, 32'h0, 8'h00);
        tbl[11] = mk(F, T, F, 32'h0, 8'h00, F, T, T, 32'h0, 8'h00);
        tbl[12] = mk(T, T, F, 32'h77777777, 8'h20, T, T, T, 32'h77777777, 8'h20);
        tbl[13] = mk(T, T, T, 32'h88888888, 8'h24, F, T, T, 32'h0, 8'h00);
        tbl[14] = mk(F, F, T, 32'h0, 8'h00, F, T, T, 32'h0, 8'h00);
        tbl[15] = mk(T, T, F, 32'h99999999, 8'h28, T, T, T, 32'h99999999, 8'h28);
        tbl[16] = mk(F, F, F, 32'h0, 8'h00, T, T, T, 32'h99999999, 8'h28);
        tbl[17] = mk(F, T, F, 32'h0, 8'h00, F, T, F, 32'h0, 8'h00);

        do_reset();
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_ready", in_ready, 1'b1);
        chk("rst_instr", out_instr, 32'h0);
        chk("rst_pc", out_pc, 8'h0);

        for (int i = 0; i < 18; i++) begin
            in_valid = tbl[i].iv;
            out_ready = tbl[i].ordy;
            flush = tbl[i].fl;
            in_instr = tbl[i].ins;
            in_pc = tbl[i].pc;
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("v%0d_valid", i), out_valid, tbl[i].ev);
            chk($sformatf("v%0d_ready", i), in_ready, tbl[i].er);
            if (tbl[i].cd) begin
                chk($sformatf("v%0d_instr", i), out_instr, tbl[i].ei);
                chk($sformatf("v%0d_pc", i), out_pc, tbl[i].ep);
            end
        end
        flush = 1'b0;
`ifdef IFID_PERF_EN
        chk("tbl_stall_cnt", stall_cnt, 4'd4);
        chk("tbl_flush_cnt", flush_cnt, 4'd3);
`endif

        do_reset();
        run(20, 1'b0, 8);
`ifdef IFID_PERF_EN
        chk("stream_stall_cnt", stall_cnt, 4'd4);
`endif

        do_reset();
        in_valid = 1'b1;
        in_instr = 32'hAAAA5555;
        in_pc = 8'h30;
        out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("pre_arst_valid", out_valid, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", out_valid, 1'b0);
        chk("arst_ready", in_ready, 1'b1);
        chk("arst_instr", out_instr, 32'h0);
        chk("arst_pc", out_pc, 8'h0);
        @(negedge clk);
        rst = 1'b0;

        do_reset();
        run(10000, 1'b1, 0);

`ifdef IFID_PERF_EN
        do_reset();
        in_valid = 1'b1;
        in_instr = 32'h12345678;
        in_pc = 8'h50;
        out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (20) @(negedge clk);
        chk("stall_sat", stall_cnt, 4'd15);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
